// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 16-bit asynchronous SRAM between the fetch stage and
// the memory stage. Each 32-bit transaction is split into two halfword accesses
// (low half at A, high half at A|1) and ends with a one-cycle done pulse to the
// requester that owns it.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-low reset
//   if_mc_*  / mc_if_*    fetch read request, fetched word and done pulse
//   mem_mc_* / mc_mem_*   memory-stage read/write request, read word and done pulse
//   mc_ram_*              SRAM address, write data, data drive enable, read data,
//                         chip/output/write enables (all active high)
module sram_arbiter #(
  parameter int unsigned ADDR_W    = 18,
  parameter bit          MEM_FIRST = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_mc_en,
  input  logic [ADDR_W-1:0] if_mc_addr,
  output logic [31:0]       mc_if_data,
  output logic              mc_if_done,
  input  logic              mem_mc_en,
  input  logic              mem_mc_rw,
  input  logic [ADDR_W-1:0] mem_mc_addr,
  input  logic [31:0]       mem_mc_wdata,
  output logic [31:0]       mc_mem_rdata,
  output logic              mc_mem_done,
  output logic [ADDR_W-1:0] mc_ram_addr,
  output logic [15:0]       mc_ram_wdata,
  output logic              mc_ram_dataoe,
  input  logic [15:0]       mc_ram_rdata,
  output logic              mc_ram_ce,
  output logic              mc_ram_oute,
  output logic              mc_ram_wre
);

  localparam logic [ADDR_W-1:0] HALF_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_e;

  state_e            state_q,     state_d;
  logic              own_mem_q,   own_mem_d;
  logic              rw_q,        rw_d;
  logic [ADDR_W-1:0] base_q,      base_d;
  logic [31:0]       wdata_q,     wdata_d;
  logic [15:0]       lo_q,        lo_d;
  logic              last_mem_q,  last_mem_d;
  logic [31:0]       if_data_q,   if_data_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              if_done_q,   if_done_d;
  logic              mem_done_q,  mem_done_d;
  logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
  logic [15:0]       ram_wdata_q, ram_wdata_d;
  logic              oe_q,        oe_d;
  logic              ce_q,        ce_d;
  logic              oute_q,      oute_d;
  logic              wre_q,       wre_d;
  logic              grant_mem_c;

  // State and output registers; SRAM controls are registered from the next state
  // so they are valid throughout the LO and HI cycles.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      own_mem_q   <= 1'b0;
      rw_q        <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      lo_q        <= '0;
      last_mem_q  <= ~MEM_FIRST;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      oe_q        <= 1'b0;
      ce_q        <= 1'b0;
      oute_q      <= 1'b0;
      wre_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      own_mem_q   <= own_mem_d;
      rw_q        <= rw_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
      last_mem_q  <= last_mem_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      oe_q        <= oe_d;
      ce_q        <= ce_d;
      oute_q      <= oute_d;
      wre_q       <= wre_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    own_mem_d   = own_mem_q;
    rw_d        = rw_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    lo_d        = lo_q;
    last_mem_d  = last_mem_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    oe_d        = 1'b0;
    ce_d        = 1'b0;
    oute_d      = 1'b0;
    wre_d       = 1'b0;

    // Memory wins when it is alone, or on a tie when fetch was granted last.
    grant_mem_c = mem_mc_en & (~if_mc_en | ~last_mem_q);

    unique case (state_q)
      S_IDLE: begin
        if (if_mc_en || mem_mc_en) begin
          own_mem_d  = grant_mem_c;
          rw_d       = grant_mem_c & mem_mc_rw;
          base_d     = (grant_mem_c ? mem_mc_addr : if_mc_addr) & ~HALF_ONE;
          wdata_d    = mem_mc_wdata;
          state_d    = S_LO;
          ram_addr_d = base_d;
          ce_d       = 1'b1;
          if (rw_d) begin
            wre_d       = 1'b1;
            oe_d        = 1'b1;
            ram_wdata_d = wdata_d[15:0];
          end else begin
            oute_d = 1'b1;
          end
        end
      end
      S_LO: begin
        lo_d       = mc_ram_rdata;
        state_d    = S_HI;
        ram_addr_d = base_q | HALF_ONE;
        ce_d       = 1'b1;
        if (rw_q) begin
          wre_d       = 1'b1;
          oe_d        = 1'b1;
          ram_wdata_d = wdata_q[31:16];
        end else begin
          oute_d = 1'b1;
        end
      end
      S_HI: begin
        state_d = S_DONE;
        if (own_mem_q) begin
          mem_done_d = 1'b1;
          if (!rw_q) mem_rdata_d = {mc_ram_rdata, lo_q};
        end else begin
          if_done_d = 1'b1;
          if_data_d = {mc_ram_rdata, lo_q};
        end
      end
      S_DONE: begin
        last_mem_d = own_mem_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mc_if_data    = if_data_q;
  assign mc_if_done    = if_done_q;
  assign mc_mem_rdata  = mem_rdata_q;
  assign mc_mem_done   = mem_done_q;
  assign mc_ram_addr   = ram_addr_q;
  assign mc_ram_wdata  = ram_wdata_q;
  assign mc_ram_dataoe = oe_q;
  assign mc_ram_ce     = ce_q;
  assign mc_ram_oute   = oute_q;
  assign mc_ram_wre    = wre_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter: asynchronous SRAM model plus a word-level
// reference memory; each scenario task checks the DUT's SRAM bus and results.
module tb_sram_arbiter;

  localparam int unsigned AW    = 18;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clock, reset;
  logic          if_mc_en;
  logic [AW-1:0] if_mc_addr;
  logic [31:0]   mc_if_data;
  logic          mc_if_done;
  logic          mem_mc_en, mem_mc_rw;
  logic [AW-1:0] mem_mc_addr;
  logic [31:0]   mem_mc_wdata;
  logic [31:0]   mc_mem_rdata;
  logic          mc_mem_done;
  logic [AW-1:0] mc_ram_addr;
  logic [15:0]   mc_ram_wdata;
  logic          mc_ram_dataoe;
  logic [15:0]   mc_ram_rdata;
  logic          mc_ram_ce, mc_ram_oute, mc_ram_wre;

  sram_arbiter #(.ADDR_W(AW), .MEM_FIRST(1'b1)) dut (
    .clock(clock), .reset(reset),
    .if_mc_en(if_mc_en), .if_mc_addr(if_mc_addr),
    .mc_if_data(mc_if_data), .mc_if_done(mc_if_done),
    .mem_mc_en(mem_mc_en), .mem_mc_rw(mem_mc_rw), .mem_mc_addr(mem_mc_addr),
    .mem_mc_wdata(mem_mc_wdata), .mc_mem_rdata(mc_mem_rdata), .mc_mem_done(mc_mem_done),
    .mc_ram_addr(mc_ram_addr), .mc_ram_wdata(mc_ram_wdata), .mc_ram_dataoe(mc_ram_dataoe),
    .mc_ram_rdata(mc_ram_rdata), .mc_ram_ce(mc_ram_ce), .mc_ram_oute(mc_ram_oute),
    .mc_ram_wre(mc_ram_wre)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Asynchronous SRAM: combinational read, write at the end of a write cycle.
  logic [15:0] sram    [0:DEPTH-1];
  logic [15:0] ref_mem [0:DEPTH-1];
  assign mc_ram_rdata = sram[mc_ram_addr];
  always @(posedge clock) if (mc_ram_ce && mc_ram_wre) sram[mc_ram_addr] <= mc_ram_wdata;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic [3:0]    ctl;      // {ce, oute, wre, dataoe}
    logic          if_done, mem_done;
    logic [31:0]   if_data, mem_rdata;
  } smp_t;

  smp_t        tr[$];
  int          n_pass, n_chk;
  logic [31:0] exp_if, exp_mem;

  function automatic smp_t snap();
    smp_t s;
    s.addr = mc_ram_addr;  s.wdata = mc_ram_wdata;
    s.ctl = {mc_ram_ce, mc_ram_oute, mc_ram_wre, mc_ram_dataoe};
    s.if_done = mc_if_done;  s.mem_done = mc_mem_done;
    s.if_data = mc_if_data;  s.mem_rdata = mc_mem_rdata;
    return s;
  endfunction

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Raise one request, sample the four cycles after it is taken, drop it on done.
  task automatic issue(input bit is_mem, input bit rw, input logic [AW-1:0] a, input logic [31:0] wd);
    tr.delete();
    mem_mc_rw = rw;  mem_mc_wdata = wd;
    if (is_mem) begin mem_mc_en = 1'b1; mem_mc_addr = a; end
    else begin if_mc_en = 1'b1; if_mc_addr = a; end
    for (int i = 0; i < 4; i++) begin
      tick();
      tr.push_back(snap());
      if (i == 2) begin if_mc_en = 1'b0; mem_mc_en = 1'b0; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; if_mc_en = 1'b1; mem_mc_en = 1'b1; mem_mc_rw = 1'b1;
    if_mc_addr = 18'h00123; mem_mc_addr = 18'h00456; mem_mc_wdata = 32'hA5A5_5A5A;
    repeat (3) tick();
    n_chk++; if ({mc_ram_ce, mc_ram_oute, mc_ram_wre, mc_ram_dataoe} !== 4'b0000)
      $display("FAIL reset_ctl: got %b exp 0000", {mc_ram_ce, mc_ram_oute, mc_ram_wre, mc_ram_dataoe}); else n_pass++;
    n_chk++; if ({mc_if_done, mc_mem_done} !== 2'b00)
      $display("FAIL reset_done: got %b exp 00", {mc_if_done, mc_mem_done}); else n_pass++;
    n_chk++; if (mc_ram_addr !== '0) $display("FAIL reset_addr: got %h exp 0", mc_ram_addr); else n_pass++;
    n_chk++; if (mc_ram_wdata !== '0) $display("FAIL reset_wdata: got %h exp 0", mc_ram_wdata); else n_pass++;
    n_chk++; if ({mc_if_data, mc_mem_rdata} !== 64'h0)
      $display("FAIL reset_data: got %h/%h exp 0/0", mc_if_data, mc_mem_rdata); else n_pass++;
    if_mc_en = 1'b0; mem_mc_en = 1'b0; mem_mc_rw = 1'b0;
    reset = 1'b1;
    tick();
    exp_if = '0; exp_mem = '0;
  endtask

  task automatic test_fetch_read();
    sram[18'h10] = 16'h5678; ref_mem[18'h10] = 16'h5678;
    sram[18'h11] = 16'h1234; ref_mem[18'h11] = 16'h1234;
    issue(1'b0, 1'b1, 18'h10, 32'hFFFF_FFFF);  // mem_mc_rw high must not matter for fetch
    n_chk++; if (tr[0].addr !== 18'h10 || tr[0].ctl !== 4'b1100)
      $display("FAIL fetch_lo: got addr %h ctl %b exp 10 1100", tr[0].addr, tr[0].ctl); else n_pass++;
    n_chk++; if (tr[1].addr !== 18'h11 || tr[1].ctl !== 4'b1100)
      $display("FAIL fetch_hi: got addr %h ctl %b exp 11 1100", tr[1].addr, tr[1].ctl); else n_pass++;
    n_chk++; if (tr[2].if_done !== 1'b1 || tr[2].mem_done !== 1'b0 || tr[2].ctl !== 4'b0000)
      $display("FAIL fetch_done: got if %b mem %b ctl %b exp 1 0 0000", tr[2].if_done, tr[2].mem_done, tr[2].ctl); else n_pass++;
    n_chk++; if (tr[2].if_data !== 32'h1234_5678)
      $display("FAIL fetch_data: got %h exp 12345678", tr[2].if_data); else n_pass++;
    n_chk++; if (tr[3].if_done !== 1'b0 || tr[3].if_data !== 32'h1234_5678)
      $display("FAIL fetch_after: got done %b data %h exp 0 12345678", tr[3].if_done, tr[3].if_data); else n_pass++;
    exp_if = 32'h1234_5678;
  endtask

  task automatic test_mem_write();
    issue(1'b1, 1'b1, 18'h21, 32'hDEAD_BEEF);
    ref_mem[18'h20] = 16'hBEEF; ref_mem[18'h21] = 16'hDEAD;
    n_chk++; if (tr[0].addr !== 18'h20 || tr[0].wdata !== 16'hBEEF || tr[0].ctl !== 4'b1011)
      $display("FAIL wr_lo: got %h %h %b exp 20 beef 1011", tr[0].addr, tr[0].wdata, tr[0].ctl); else n_pass++;
    n_chk++; if (tr[1].addr !== 18'h21 || tr[1].wdata !== 16'hDEAD || tr[1].ctl !== 4'b1011)
      $display("FAIL wr_hi: got %h %h %b exp 21 dead 1011", tr[1].addr, tr[1].wdata, tr[1].ctl); else n_pass++;
    n_chk++; if (tr[2].mem_done !== 1'b1 || tr[2].if_done !== 1'b0 || tr[2].ctl !== 4'b0000 || tr[3].ctl !== 4'b0000)
      $display("FAIL wr_done: got mem %b if %b ctl %b/%b exp 1 0 0000/0000", tr[2].mem_done, tr[2].if_done, tr[2].ctl, tr[3].ctl); else n_pass++;
    n_chk++; if (tr[2].mem_rdata !== exp_mem)
      $display("FAIL wr_rdata_hold: got %h exp %h", tr[2].mem_rdata, exp_mem); else n_pass++;
    n_chk++; if (sram[18'h20] !== 16'hBEEF || sram[18'h21] !== 16'hDEAD)
      $display("FAIL wr_sram: got %h%h exp deadbeef", sram[18'h21], sram[18'h20]); else n_pass++;
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      bit            is_mem, rw;
      logic [AW-1:0] a, lo, hi;
      logic [31:0]   wd, word;
      bit            wr;
      is_mem = 1'($urandom_range(0, 1));
      rw     = 1'($urandom_range(0, 1));
      a      = ($urandom_range(0, 9) == 0) ? AW'($urandom) : AW'($urandom_range(0, 31));
      wd     = $urandom;
      wr     = is_mem && rw;
      lo     = AW'((a / 2) * 2);
      hi     = lo + AW'(1);
      word   = {ref_mem[hi], ref_mem[lo]};
      issue(is_mem, rw, a, wd);
      n_chk++; if (tr[0].addr !== lo || tr[0].ctl !== (wr ? 4'b1011 : 4'b1100) || (wr && tr[0].wdata !== wd[15:0]))
        $display("FAIL rnd_lo[%0d]: got %h %b %h exp %h %b %h", t, tr[0].addr, tr[0].ctl, tr[0].wdata, lo, wr ? 4'b1011 : 4'b1100, wd[15:0]); else n_pass++;
      n_chk++; if (tr[1].addr !== hi || tr[1].ctl !== (wr ? 4'b1011 : 4'b1100) || (wr && tr[1].wdata !== wd[31:16]))
        $display("FAIL rnd_hi[%0d]: got %h %b %h exp %h %b %h", t, tr[1].addr, tr[1].ctl, tr[1].wdata, hi, wr ? 4'b1011 : 4'b1100, wd[31:16]); else n_pass++;
      n_chk++; if (tr[2].mem_done !== is_mem || tr[2].if_done !== !is_mem || tr[3].mem_done !== 1'b0 || tr[3].if_done !== 1'b0)
        $display("FAIL rnd_done[%0d]: got %b%b/%b%b exp %b%b/00", t, tr[2].mem_done, tr[2].if_done, tr[3].mem_done, tr[3].if_done, is_mem, !is_mem); else n_pass++;
      if (wr) begin
        ref_mem[lo] = wd[15:0]; ref_mem[hi] = wd[31:16];
      end else if (is_mem) exp_mem = word;
      else exp_if = word;
      n_chk++; if (tr[2].if_data !== exp_if || tr[2].mem_rdata !== exp_mem)
        $display("FAIL rnd_data[%0d]: got %h/%h exp %h/%h", t, tr[2].if_data, tr[2].mem_rdata, exp_if, exp_mem); else n_pass++;
      for (int i = 0; i < 4; i++) begin
        n_chk++; if ((tr[i].ctl[2] && tr[i].ctl[1]) || (tr[i].ctl[0] && !tr[i].ctl[1]))
          $display("FAIL rnd_excl[%0d.%0d]: got ctl %b", t, i, tr[i].ctl); else n_pass++;
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [31:0] wm, wi;
    reset = 1'b0; tick(); reset = 1'b1; tick();
    exp_if = '0; exp_mem = '0;
    wm = {ref_mem[18'h41], ref_mem[18'h40]};
    wi = {ref_mem[18'h81], ref_mem[18'h80]};
    mem_mc_en = 1'b1; mem_mc_rw = 1'b0; mem_mc_addr = 18'h40;
    if_mc_en = 1'b1; if_mc_addr = 18'h81;
    for (int i = 0; i <= 10; i++) begin
      tick();
      n_chk++; if (mc_mem_done !== (i == 2 || i == 10) || mc_if_done !== (i == 6))
        $display("FAIL rr_done[%0d]: got mem %b if %b exp %b %b", i, mc_mem_done, mc_if_done, i == 2 || i == 10, i == 6); else n_pass++;
      if (i == 2 || i == 10) begin
        n_chk++; if (mc_mem_rdata !== wm) $display("FAIL rr_mem_data[%0d]: got %h exp %h", i, mc_mem_rdata, wm); else n_pass++;
      end
      if (i == 6) begin
        n_chk++; if (mc_if_data !== wi) $display("FAIL rr_if_data: got %h exp %h", mc_if_data, wi); else n_pass++;
      end
    end
    mem_mc_en = 1'b0; if_mc_en = 1'b0;
    repeat (2) tick();
    exp_if = wi; exp_mem = wm;
  endtask

  task automatic test_reset_mid_write();
    mem_mc_en = 1'b1; mem_mc_rw = 1'b1; mem_mc_addr = 18'h60; mem_mc_wdata = $urandom;
    tick(); tick();
    n_chk++; if (mc_ram_wre !== 1'b1 || mc_ram_addr !== 18'h61)
      $display("FAIL rst_mid_hi: got wre %b addr %h exp 1 61", mc_ram_wre, mc_ram_addr); else n_pass++;
    reset = 1'b0; mem_mc_en = 1'b0;
    tick();
    n_chk++; if ({mc_ram_ce, mc_ram_wre, mc_ram_dataoe, mc_mem_done} !== 4'b0000)
      $display("FAIL rst_mid_abort: got %b exp 0000", {mc_ram_ce, mc_ram_wre, mc_ram_dataoe, mc_mem_done}); else n_pass++;
    reset = 1'b1;
    tick();
    n_chk++; if (mc_mem_done !== 1'b0 || mc_ram_ce !== 1'b0)
      $display("FAIL rst_mid_nodone: got done %b ce %b exp 0 0", mc_mem_done, mc_ram_ce); else n_pass++;
    // Whatever halves reached the SRAM are the new contents.
    ref_mem[18'h60] = sram[18'h60]; ref_mem[18'h61] = sram[18'h61];
    exp_if = '0; exp_mem = '0;
    issue(1'b0, 1'b0, 18'h10, '0);
    n_chk++; if (tr[2].if_done !== 1'b1 || tr[2].if_data !== {ref_mem[18'h11], ref_mem[18'h10]})
      $display("FAIL rst_mid_fetch: got %b %h exp 1 %h", tr[2].if_done, tr[2].if_data, {ref_mem[18'h11], ref_mem[18'h10]}); else n_pass++;
    exp_if = {ref_mem[18'h11], ref_mem[18'h10]};
  endtask

  task automatic test_max_addr();
    logic [31:0] w;
    w = $urandom;
    sram[18'h3FFFE] = w[15:0]; sram[18'h3FFFF] = w[31:16];
    ref_mem[18'h3FFFE] = w[15:0]; ref_mem[18'h3FFFF] = w[31:16];
    issue(1'b1, 1'b0, 18'h3FFFE, '0);
    n_chk++; if (tr[0].addr !== 18'h3FFFE || tr[1].addr !== 18'h3FFFF)
      $display("FAIL max_mem_addr: got %h/%h exp 3fffe/3ffff", tr[0].addr, tr[1].addr); else n_pass++;
    n_chk++; if (tr[2].mem_done !== 1'b1 || tr[2].mem_rdata !== w)
      $display("FAIL max_mem_data: got %b %h exp 1 %h", tr[2].mem_done, tr[2].mem_rdata, w); else n_pass++;
    exp_mem = w;
    issue(1'b0, 1'b0, 18'h3FFFF, '0);
    n_chk++; if (tr[0].addr !== 18'h3FFFE || tr[1].addr !== 18'h3FFFF || tr[2].if_data !== w)
      $display("FAIL max_if: got %h/%h %h exp 3fffe/3ffff %h", tr[0].addr, tr[1].addr, tr[2].if_data, w); else n_pass++;
    exp_if = w;
  endtask

  task automatic test_back_to_back();
    logic [31:0] w;
    w = {ref_mem[18'h0B], ref_mem[18'h0A]};
    if_mc_en = 1'b1; if_mc_addr = 18'h0A;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_chk++; if (mc_if_done !== (i == 2 || i == 6) || mc_mem_done !== 1'b0)
        $display("FAIL b2b_done[%0d]: got if %b mem %b exp %b 0", i, mc_if_done, mc_mem_done, i == 2 || i == 6); else n_pass++;
      if (i == 4) begin
        n_chk++; if (mc_ram_addr !== 18'h0A || mc_ram_oute !== 1'b1)
          $display("FAIL b2b_reissue: got addr %h oute %b exp 0a 1", mc_ram_addr, mc_ram_oute); else n_pass++;
      end
      if (i == 6) begin
        n_chk++; if (mc_if_data !== w) $display("FAIL b2b_data: got %h exp %h", mc_if_data, w); else n_pass++;
        if_mc_en = 1'b0;
      end
    end
    exp_if = w;
  endtask

  initial begin
    n_pass = 0; n_chk = 0;
    exp_if = '0; exp_mem = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      sram[i] = 16'($urandom);
      ref_mem[i] = sram[i];
    end
    reset = 1'b0; if_mc_en = 1'b0; mem_mc_en = 1'b0; mem_mc_rw = 1'b0;
    if_mc_addr = '0; mem_mc_addr = '0; mem_mc_wdata = '0;
    test_reset();
    test_fetch_read();
    test_mem_write();
    test_random();
    test_simultaneous();
    test_reset_mid_write();
    test_max_addr();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
